// File: rtl/dram_port_arbiter.sv
// Shares one DRAM port between a read-fetch stream and a posted-write FIFO.
// Round-robin arbitration with a read-after-write hazard check against buffered writes.
module dram_port_arbiter #(
  parameter int WB_DEPTH   = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        rd_gnt,
  output logic        rd_rvalid,
  output logic [31:0] rd_rdata,
  input  logic        wb_en,
  input  logic [31:0] wb_addr,
  input  logic [31:0] wb_data_in,
  output logic        wb_ready,
  output logic        ram_ena,
  output logic        ram_wea,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_data_out,
  input  logic [31:0] ram_data_in,
  output logic        wb_empty,
  output logic        busy
);

  localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CNT_W = $clog2(WB_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WB_DEPTH);

  // Handshakes: a read transfers in any cycle with rd_req && rd_gnt (rd_addr held until then);
  // a write-back transfers in any cycle with wb_en && wb_ready.
  typedef enum logic {GNT_WRITE = 1'b0, GNT_READ = 1'b1} grant_e;

  grant_e              last_grant, last_grant_next;
  logic [31:0]         fifo_addr [WB_DEPTH];
  logic [31:0]         fifo_data [WB_DEPTH];
  logic [WB_DEPTH-1:0] entry_vld;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [RD_LATENCY-1:0] vld_sr;

  logic full, empty, hazard, rd_elig, wr_elig;
  logic gnt_rd, gnt_wr, push, pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign wb_ready = reset && !full;
  assign wb_empty = empty;
  assign push     = wb_en && wb_ready;
  assign pop      = gnt_wr;

  // Only registered entries are compared, so a write pushed this cycle orders after a granted read.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (entry_vld[i] && (fifo_addr[i] == rd_addr)) hazard = 1'b1;
    end
  end

  assign rd_elig = rd_req && !hazard;
  assign wr_elig = !empty;

  // Arbitration state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_grant <= GNT_WRITE;
    else        last_grant <= last_grant_next;
  end

  // Grant selection and next round-robin state
  always_comb begin
    gnt_rd          = 1'b0;
    gnt_wr          = 1'b0;
    last_grant_next = last_grant;
    if (reset) begin
      if (full) begin
        gnt_wr = 1'b1;
      end else if (rd_elig && wr_elig) begin
        if (last_grant == GNT_WRITE) gnt_rd = 1'b1;
        else                         gnt_wr = 1'b1;
      end else if (rd_elig) begin
        gnt_rd = 1'b1;
      end else if (wr_elig) begin
        gnt_wr = 1'b1;
      end
    end
    if (gnt_rd) last_grant_next = GNT_READ;
    if (gnt_wr) last_grant_next = GNT_WRITE;
  end

  // DRAM port drive
  always_comb begin
    rd_gnt       = gnt_rd;
    ram_ena      = 1'b0;
    ram_wea      = 1'b0;
    ram_addr     = '0;
    ram_data_out = '0;
    if (gnt_rd) begin
      ram_ena  = 1'b1;
      ram_addr = rd_addr;
    end else if (gnt_wr) begin
      ram_ena      = 1'b1;
      ram_wea      = 1'b1;
      ram_addr     = fifo_addr[rd_ptr];
      ram_data_out = fifo_data[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wb_addr;
      fifo_data[wr_ptr] <= wb_data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      entry_vld <= '0;
    end else begin
      if (pop) begin
        entry_vld[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        entry_vld[wr_ptr] <= 1'b1;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_sr <= '0;
    else        vld_sr <= (vld_sr << 1) | RD_LATENCY'(gnt_rd);
  end

  assign rd_rvalid = vld_sr[RD_LATENCY-1];
  assign rd_rdata  = ram_data_in;
  assign busy      = !empty || (|vld_sr);

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench for dram_port_arbiter: directed scenarios plus random traffic,
// with a DRAM model and a spec-level reference for grants, write order and read data.
module tb_dram_port_arbiter;

  localparam int WB_DEPTH   = 4;
  localparam int RD_LATENCY = 1;

  logic        clk;
  logic        rst_n;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_gnt;
  logic        rd_rvalid;
  logic [31:0] rd_rdata;
  logic        wb_en;
  logic [31:0] wb_addr;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        ram_ena;
  logic        ram_wea;
  logic [31:0] ram_addr;
  logic [31:0] ram_data_out;
  logic [31:0] ram_data_in;
  logic        wb_empty;
  logic        busy;

  dram_port_arbiter #(.WB_DEPTH(WB_DEPTH), .RD_LATENCY(RD_LATENCY)) dut (
    .clk(clk), .reset(rst_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data_in(wb_data), .wb_ready(wb_ready),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addr(ram_addr),
    .ram_data_out(ram_data_out), .ram_data_in(ram_data_in),
    .wb_empty(wb_empty), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] data; int due; } rd_t;

  wr_t         wr_q [$];
  rd_t         rd_q [$];
  logic [31:0] dram    [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] rd_pipe [RD_LATENCY];
  logic        last_w;
  int          cyc;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  logic        m_hz, m_rd_el, m_wr_el, m_full, m_exp_rv;
  int          m_pred;
  logic [31:0] m_val;

  initial begin
    last_w      = 1'b1;
    cyc         = 0;
    ram_data_in = '0;
    for (int i = 0; i < RD_LATENCY; i++) rd_pipe[i] = '0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check_eq("rst_wb_ready", wb_ready, 0);
      check_eq("rst_rd_gnt", rd_gnt, 0);
      check_eq("rst_rd_rvalid", rd_rvalid, 0);
      check_eq("rst_ram_ena", ram_ena, 0);
      check_eq("rst_wb_empty", wb_empty, 1);
      check_eq("rst_busy", busy, 0);
      wr_q.delete();
      rd_q.delete();
      last_w  = 1'b1;
      ref_mem = dram;
    end else begin
      m_full  = (wr_q.size() == WB_DEPTH);
      m_hz    = 1'b0;
      foreach (wr_q[i]) if (wr_q[i].addr == rd_addr) m_hz = 1'b1;
      m_rd_el = rd_req && !m_hz;
      m_wr_el = (wr_q.size() != 0);
      if (m_full)                   m_pred = 2;
      else if (m_rd_el && m_wr_el)  m_pred = last_w ? 1 : 2;
      else if (m_rd_el)             m_pred = 1;
      else if (m_wr_el)             m_pred = 2;
      else                          m_pred = 0;

      check_eq("busy", busy, (wr_q.size() != 0) || (rd_q.size() != 0));
      check_eq("wb_empty", wb_empty, wr_q.size() == 0);
      check_eq("wb_ready", wb_ready, !m_full);

      m_exp_rv = (rd_q.size() != 0) && (rd_q[0].due == cyc);
      check_eq("rd_rvalid", rd_rvalid, m_exp_rv);
      if (m_exp_rv) begin
        check_eq("rd_rdata", rd_rdata, rd_q[0].data);
        void'(rd_q.pop_front());
      end

      check_eq("rd_gnt", rd_gnt, m_pred == 1);
      check_eq("ram_ena", ram_ena, m_pred != 0);
      check_eq("ram_wea", ram_wea, m_pred == 2);
      if (m_pred == 1) begin
        check_eq("rd_ram_addr", ram_addr, rd_addr);
        m_val = ref_mem.exists(rd_addr) ? ref_mem[rd_addr] : dflt(rd_addr);
        rd_q.push_back('{data: m_val, due: cyc + RD_LATENCY});
        last_w = 1'b0;
      end else if (m_pred == 2) begin
        check_eq("wr_ram_addr", ram_addr, wr_q[0].addr);
        check_eq("wr_ram_data", ram_data_out, wr_q[0].data);
        void'(wr_q.pop_front());
        last_w = 1'b1;
      end else begin
        check_eq("idle_ram_addr", ram_addr, 0);
        check_eq("idle_ram_data", ram_data_out, 0);
      end

      if (wb_en && !m_full) begin
        wr_q.push_back('{addr: wb_addr, data: wb_data});
        ref_mem[wb_addr] = wb_data;
      end
    end

    // DRAM model acts on what the DUT actually drove this cycle
    if (ram_ena && ram_wea) dram[ram_addr] = ram_data_out;
    for (int i = RD_LATENCY - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
    if (ram_ena && !ram_wea) rd_pipe[0] = dram.exists(ram_addr) ? dram[ram_addr] : dflt(ram_addr);
    else                     rd_pipe[0] = '0;
    ram_data_in = rd_pipe[RD_LATENCY-1];
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      rd_req = 1'b0;
      wb_en  = 1'b0;
    end
  endtask

  // After a read was granted, walk to its response cycle and check the data there
  task automatic expect_read_data(input string tag, input logic [31:0] exp);
    for (int k = 1; k <= RD_LATENCY; k++) begin
      tick();
      rd_req = 1'b0;
      wb_en  = 1'b0;
      #1;
      if (k == RD_LATENCY) begin
        check_eq({tag, "_rvalid"}, rd_rvalid, 1);
        check_eq({tag, "_rdata"}, rd_rdata, exp);
      end else begin
        check_eq({tag, "_rvalid_early"}, rd_rvalid, 0);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  int          first_full;
  int          waits;
  logic        rd_done;
  logic [31:0] pick;

  initial begin
    rst_n   = 1'b0;
    rd_req  = 1'b1;
    rd_addr = 32'h40;
    wb_en   = 1'b1;
    wb_addr = 32'h40;
    wb_data = 32'h1;
    dram[32'h40]  = 32'hDEAD_BEEF;
    dram[32'h500] = 32'h0BAD_0500;

    // reset with requests asserted: nothing may be granted or accepted
    repeat (3) tick();

    // single read right after release
    tick();
    rst_n   = 1'b1;
    rd_req  = 1'b1;
    rd_addr = 32'h40;
    wb_en   = 1'b0;
    #1;
    check_eq("rd0_gnt", rd_gnt, 1);
    check_eq("rd0_ram_addr", ram_addr, 32'h40);
    check_eq("rd0_wb_ready", wb_ready, 1);
    expect_read_data("rd0", 32'hDEAD_BEEF);
    check_eq("rd0_busy_during", busy, 1);
    tick();
    #1;
    check_eq("rd0_busy_after", busy, 0);

    // same-address push on a granted read: read sees the old value
    idle(2);
    tick();
    rd_req  = 1'b1;
    rd_addr = 32'h500;
    wb_en   = 1'b1;
    wb_addr = 32'h500;
    wb_data = 32'hCAFE_F00D;
    #1;
    check_eq("same_gnt", rd_gnt, 1);
    expect_read_data("same_old", 32'h0BAD_0500);
    check_eq("same_write_wea", ram_wea, 1);
    check_eq("same_write_addr", ram_addr, 32'h500);
    idle(2);
    tick();
    rd_req  = 1'b1;
    rd_addr = 32'h500;
    #1;
    check_eq("same_new_gnt", rd_gnt, 1);
    expect_read_data("same_new", 32'hCAFE_F00D);
    idle(3);

    // RAW hazard: two older writes buffered, then 0x100 pushed, then read of 0x100
    for (int n = 0; n < 5; n++) begin
      tick();
      rd_req  = 1'b1;
      rd_addr = 32'h2000;
      wb_en   = 1'b1;
      wb_addr = (n == 4) ? 32'h100 : 32'h6000 + 32'(n << 2);
      wb_data = (n == 4) ? 32'h1234 : $urandom;
    end
    #1;
    check_eq("raw_prior_read_gnt", rd_gnt, 1);
    tick();
    rd_req  = 1'b1;
    rd_addr = 32'h100;
    wb_en   = 1'b0;
    #1;
    waits = 0;
    while (!rd_gnt && waits < 12) begin
      waits++;
      tick();
      #1;
    end
    check_eq("raw_blocked_cycles", waits, 3);
    check_eq("raw_fifo_drained", wb_empty, 1);
    expect_read_data("raw", 32'h1234);
    idle(3);

    // reset mid-operation: 3 writes buffered and a read in flight
    for (int n = 0; n < 5; n++) begin
      tick();
      rd_req  = 1'b1;
      rd_addr = 32'h3000;
      wb_en   = 1'b1;
      wb_addr = 32'h7000 + 32'(n << 2);
      wb_data = $urandom;
    end
    #1;
    check_eq("midrst_pre_gnt", rd_gnt, 1);
    tick();
    rst_n  = 1'b0;
    rd_req = 1'b0;
    wb_en  = 1'b0;
    #1;
    check_eq("midrst_rvalid", rd_rvalid, 0);
    check_eq("midrst_wb_empty", wb_empty, 1);
    check_eq("midrst_ram_ena", ram_ena, 0);
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1;
      check_eq("midrst_no_write", ram_ena, 0);
      check_eq("midrst_no_rvalid", rd_rvalid, 0);
      tick();
    end

    // fill + round-robin: read first, then strict R/W alternation even through full
    first_full = -1;
    for (int n = 0; n < 12; n++) begin
      tick();
      rd_req  = 1'b1;
      rd_addr = 32'h3000;
      wb_en   = 1'b1;
      wb_addr = 32'h5000 + 32'(n << 2);
      wb_data = $urandom;
      #1;
      check_eq("rr_ena", ram_ena, 1);
      check_eq("rr_wea", ram_wea, 32'(n % 2));
      if (!wb_ready && first_full < 0) begin
        first_full = n;
        check_eq("fill_full_write_wins", rd_gnt, 0);
      end
    end
    check_eq("fill_first_full_cycle", first_full, 7);
    idle(8);

    // random traffic over a small address set to provoke hazards
    rd_done = 1'b0;
    for (int n = 0; n < 400; n++) begin
      tick();
      if (rd_done) rd_req = 1'b0;
      if (!rd_req && $urandom_range(0, 1) == 1) begin
        pick    = 32'h100 + 32'($urandom_range(0, 3) << 2);
        rd_req  = 1'b1;
        rd_addr = pick;
      end
      wb_en   = ($urandom_range(0, 2) != 0);
      wb_addr = 32'h100 + 32'($urandom_range(0, 3) << 2);
      wb_data = $urandom;
      if (n == 250) rst_n = 1'b0;
      if (n == 252) rst_n = 1'b1;
      #1;
      rd_done = rd_gnt;
    end
    idle(12);
    check_eq("final_writes_drained", wr_q.size(), 0);
    check_eq("final_reads_returned", rd_q.size(), 0);
    check_eq("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
